// File: rtl/fifo_uart_drain_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_drain_if
//  Purpose  : Read-port bundle between a byte FIFO and its drain.
//             master = the reader (drives the read strobe),
//             slave  = the FIFO (drives empty flag and read data).
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_uart_drain_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_drain.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_drain
//  Purpose  : Pops bytes from a FIFO one at a time and serialises each one
//             LSB-first as a UART frame on tx (8N1 by default).
//             Optional feature macro: PARITY_EN -- when defined, an even
//             parity bit is inserted between the data bits and the stop bit
//             (8E1 frame).
//  Revision : 1.0  initial release
// ============================================================================
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 16,   // clk cycles per UART bit, >= 2
  parameter int DATA_W       = 8     // FIFO word / UART payload width, >= 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         ena,
  fifo_uart_drain_if.master fifo,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  // Pop request: set by an IDLE cycle that saw ena && !fifo_empty, so the
  // read strobe is issued in the following cycle. This leaves one plain IDLE
  // cycle between back-to-back frames.
  logic              pend_q;
`ifdef PARITY_EN
  logic              parity_q;
`endif

  logic              w_baud_last;
  logic              w_bit_last;
  logic              w_timed;
  logic              w_rd_en;

  assign w_baud_last = (baud_q == C_BAUD_LAST);
  assign w_bit_last  = (bit_q == C_BIT_LAST);

  // Baud counter only runs while a serial bit is on the line.
  always_comb begin
    w_timed = 1'b0;
    case (state_q)
      S_START,
      S_DATA,
`ifdef PARITY_EN
      S_PARITY,
`endif
      S_STOP:  w_timed = 1'b1;
      default: w_timed = 1'b0;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: POP/LOAD cover the FIFO read latency, bit states each
  // last one full baud period.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q && !fifo.fifo_empty) begin
          state_d = S_POP;
        end
      end
      S_POP:   state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: begin
        if (w_baud_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last && w_bit_last) begin
`ifdef PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: tx is idle-high everywhere except start/data/parity.
  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    frame_done = 1'b0;
    w_rd_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The pop cycle itself already counts as busy.
        busy    = pend_q;
        // Gate with the live empty flag so the FIFO can never be under-read.
        w_rd_en = pend_q && !fifo.fifo_empty;
      end
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
`ifdef PARITY_EN
      S_PARITY: tx = parity_q;
`endif
      S_STOP:  frame_done = w_baud_last;
      default: begin
        tx = 1'b1;
      end
    endcase
  end

  assign fifo.fifo_rd_en = w_rd_en;

  // Pop request, baud/bit counters and the payload shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      // ena is looked at only while idle and only for the next pop.
      pend_q <= (state_q == S_IDLE) && !pend_q && ena && !fifo.fifo_empty;

      // Cleared on every state entry so each bit gets a full period.
      if (state_d != state_q) begin
        baud_q <= '0;
      end else if (w_timed) begin
        baud_q <= baud_q + 1'b1;
      end else begin
        baud_q <= '0;
      end

      if (state_d != S_DATA) begin
        bit_q <= '0;
      end else if ((state_q == S_DATA) && w_baud_last) begin
        bit_q <= bit_q + 1'b1;
      end

      if (state_q == S_LOAD) begin
        shift_q <= fifo.fifo_rd_data;
      end else if ((state_q == S_DATA) && w_baud_last) begin
        shift_q <= shift_q >> 1;
      end
    end
  end

`ifdef PARITY_EN
  // Even parity of the payload, captured alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (state_q == S_LOAD) begin
      parity_q <= ^fifo.fifo_rd_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_drain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_drain
//  Purpose  : Self-checking bench for fifo_uart_drain (CLKS_PER_BIT=4,
//             DATA_W=8) with a frame-timeline model and a FIFO responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_drain;
  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef PARITY_EN
  localparam int NB  = DW + 3;
  localparam int FD_OFS = 46;                // rd_en cycle -> frame_done cycle
  localparam logic [10:0] PAT_A5 = 11'b10101001010;
`else
  localparam int NB  = DW + 2;
  localparam int FD_OFS = 42;
  localparam logic [10:0] PAT_A5 = 11'b00_1101001010;
`endif
  localparam int FL  = 3 + CPB * NB;         // frame cycles starting at rd_en

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic tx, busy, frame_done;

  fifo_uart_drain_if #(.DATA_W(DW)) ifc ();

  fifo_uart_drain #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .fifo       (ifc),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] push_q[$];
  logic       rd_en_s = 1'b0;

  logic tx_log   [0:4095];
  logic busy_log [0:4095];
  int   rd_cycs[$];
  int   fd_cycs[$];

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO responder: one-cycle read latency, pushes land shortly after an edge.
  always @(posedge clk) begin
    if (rd_en_s && fq.size() > 0) ifc.fifo_rd_data <= fq.pop_front();
    #1;
    while (push_q.size() > 0) begin
      fq.push_back(push_q[0]);
      exp_q.push_back(push_q[0]);
      void'(push_q.pop_front());
    end
    ifc.fifo_empty = (fq.size() == 0);
  end

  // Model: m_k = cycle index within the current frame (0 = pop cycle), -1 idle.
  int         m_k = -1;
  logic [7:0] m_byte = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= -1;
    end else if (m_k < 0) begin
      if (ena && ifc.fifo_empty === 1'b0 && exp_q.size() > 0) begin
        m_byte <= exp_q.pop_front();
        m_k    <= 0;
      end
    end else if (m_k == FL - 1) begin
      m_k <= -1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return b[idx-1];
`ifdef PARITY_EN
    if (idx == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Compare process: every cycle, mid-period.
  logic e_tx, e_busy, e_rd, e_fd;
  always @(negedge clk) begin
    e_rd   = (m_k == 0);
    e_busy = (m_k >= 0);
    e_fd   = (m_k == FL - 1);
    e_tx   = (m_k < 3) ? 1'b1 : exp_bit(m_byte, (m_k - 3) / CPB);
    rd_en_s = ifc.fifo_rd_en;
    if (cyc < 4096) begin
      tx_log[cyc]   = tx;
      busy_log[cyc] = busy;
    end
    if (ifc.fifo_rd_en === 1'b1) rd_cycs.push_back(cyc);
    if (frame_done === 1'b1) fd_cycs.push_back(cyc);
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("rd_en", ifc.fifo_rd_en, e_rd);
    chk("frame_done", frame_done, e_fd);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rd(input int n);
    int t = 0;
    while (rd_cycs.size() <= n && t < 300) begin tick(1); t++; end
    if (rd_cycs.size() <= n) chk_int("timeout_rd", rd_cycs.size(), n + 1);
  endtask

  task automatic wait_fd(input int n);
    int t = 0;
    while (fd_cycs.size() <= n && t < 300) begin tick(1); t++; end
    if (fd_cycs.size() <= n) chk_int("timeout_fd", fd_cycs.size(), n + 1);
  endtask

  int r, f, e;
  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    // 1: reset then idle with an empty FIFO
    tick(5);
    rst_n = 1'b1;
    tick(20);
    chk_int("t1_no_pop", rd_cycs.size(), 0);

    // 2: single frame 0xA5
    push_q.push_back(8'hA5);
    wait_rd(0);
    wait_fd(0);
    tick(2);
    if (rd_cycs.size() > 0 && fd_cycs.size() > 0) begin
      r = rd_cycs[0];
      f = fd_cycs[0];
      chk_int("t2_rd_cnt", rd_cycs.size(), 1);
      chk_int("t2_fd_ofs", f - r, FD_OFS);
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < CPB; j++)
          chk("t2_pattern", tx_log[r + 3 + CPB * i + j], PAT_A5[i]);
      chk("t2_pre_start_high", tx_log[r + 2], 1'b1);
      chk("t2_busy_last", busy_log[f], 1'b1);
      chk("t2_busy_drop", busy_log[f + 1], 1'b0);
    end

    // 3: back-to-back 0x00, 0xFF
    push_q.push_back(8'h00);
    push_q.push_back(8'hFF);
    wait_rd(2);
    wait_fd(2);
    tick(30);
    chk_int("t3_rd_cnt", rd_cycs.size(), 3);
    if (rd_cycs.size() > 2 && fd_cycs.size() > 1)
      chk_int("t3_gap", rd_cycs[2] - fd_cycs[1], 2);

    // 4: ena low during DATA of 0x3C
    push_q.push_back(8'h3C);
    wait_rd(3);
    tick(10);
    ena = 1'b0;
    push_q.push_back(8'h11);
    wait_fd(3);
    tick(20);
    chk_int("t4_fd_cnt", fd_cycs.size(), 4);
    chk_int("t4_no_pop", rd_cycs.size(), 4);
    ena = 1'b1;
    e = cyc;
    wait_rd(4);
    if (rd_cycs.size() > 4) chk_int("t4_resume", rd_cycs[4] - e, 1);
    wait_fd(4);
    tick(3);

    // 5: reset during data bit 4 of 0x81
    push_q.push_back(8'h81);
    wait_rd(5);
    if (rd_cycs.size() > 5) begin
      r = rd_cycs[5];
      for (int t = 0; t < 100 && cyc < r + 24; t++) tick(1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_tx_async", tx, 1'b1);
    chk("t5_busy_async", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk_int("t5_no_pop", rd_cycs.size(), 6);
    chk_int("t5_fd_cnt", fd_cycs.size(), 5);
    push_q.push_back(8'h5A);
    wait_rd(6);
    wait_fd(5);
    tick(3);

`ifdef PARITY_EN
    // 6: parity frames 0xA5, 0x07
    push_q.push_back(8'hA5);
    push_q.push_back(8'h07);
    wait_rd(8);
    wait_fd(7);
    tick(3);
    if (rd_cycs.size() > 8 && fd_cycs.size() > 7) begin
      chk_int("t6_len_a", fd_cycs[6] - rd_cycs[7], 46);
      chk_int("t6_len_b", fd_cycs[7] - rd_cycs[8], 46);
      chk("t6_par_a5", tx_log[rd_cycs[7] + 3 + CPB * 9 + 1], 1'b0);
      chk("t6_par_07", tx_log[rd_cycs[8] + 3 + CPB * 9 + 1], 1'b1);
    end
`endif

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
